fb_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM between video scan-out and a host write port.

---
 rtl/fb_mem_arbiter_if.sv | 56 +++++
 rtl/fb_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_mem_arbiter_if.sv
// Framebuffer arbiter bus: scan-out read port, host write port, RAM port.
// Optional macro FB_READBACK_EN adds the host read port signals.
// slave  = arbiter side, master = client/RAM side.
interface fb_mem_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8
);
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic [DATA_W-1:0] vid_data;
   logic              vid_valid;

   logic              host_wr_valid;
   logic              host_wr_ready;
   logic [ADDR_W-1:0] host_wr_addr;
   logic [DATA_W-1:0] host_wr_data;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

`ifdef FB_READBACK_EN
   logic              host_rd_valid;
   logic [ADDR_W-1:0] host_rd_addr;
   logic              host_rd_ready;
   logic [DATA_W-1:0] host_rd_data;
   logic              host_rd_dvalid;
`endif

   modport slave (
`ifdef FB_READBACK_EN
      input  host_rd_valid, host_rd_addr,
      output host_rd_ready, host_rd_data, host_rd_dvalid,
`endif
      input  vid_req, vid_addr,
      output vid_data, vid_valid,
      input  host_wr_valid, host_wr_addr, host_wr_data,
      output host_wr_ready,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport master (
`ifdef FB_READBACK_EN
      output host_rd_valid, host_rd_addr,
      input  host_rd_ready, host_rd_data, host_rd_dvalid,
`endif
      output vid_req, vid_addr,
      input  vid_data, vid_valid,
      output host_wr_valid, host_wr_addr, host_wr_data,
      input  host_wr_ready,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: scan-out reads always win; host writes are queued in a
// small FIFO and drain into every RAM cycle the scan-out leaves free.
// Optional macro FB_READBACK_EN adds a host read path, granted only when the
// scan-out is idle and the write FIFO is empty so reads see all earlier writes.
module fb_mem_arbiter #(
   parameter  int ADDR_W     = 15,
   parameter  int DATA_W     = 8,
   parameter  int FIFO_DEPTH = 4,
   parameter  int STALL_W    = 16,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int LVL_W      = PTR_W + 1
) (
   input  logic                clkin_i,
   input  logic                rst_i,
   fb_mem_arbiter_if.slave     bus,
   output logic [LVL_W-1:0]    fifo_level_o,
   output logic [STALL_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      GNT_IDLE = 2'd0,
      GNT_VID  = 2'd1,
      GNT_WR   = 2'd2,
      GNT_RD   = 2'd3
   } grant_e;

   grant_e              grant;

   logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [STALL_W-1:0]  stall_q, stall_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                vid_valid_q, vid_valid_d;
   logic                fifo_full, fifo_empty, push, pop;

   assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign fifo_empty = (level_q == '0);
   // Ready comes from the registered level, so a pop while full cannot admit a
   // same-cycle push; ready rises one cycle after the pop.
   assign push       = bus.host_wr_valid && !fifo_full;
   assign pop        = (grant == GNT_WR);

   // Per-cycle grant; reset forces idle so the RAM never sees a write under reset.
   always_comb begin
      grant = GNT_IDLE;
      if (!rst_i) begin
         if (bus.vid_req) begin
            grant = GNT_VID;
         end else if (!fifo_empty) begin
            grant = GNT_WR;
`ifdef FB_READBACK_EN
         end else if (bus.host_rd_valid) begin
            grant = GNT_RD;
`endif
         end
      end
   end

   // RAM port mux; idle cycles keep presenting the last address.
   always_comb begin
      mem_addr_d    = mem_addr_q;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = fifo_data_q[rd_ptr_q];
      case (grant)
         GNT_VID: mem_addr_d = bus.vid_addr;
         GNT_WR: begin
            mem_addr_d = fifo_addr_q[rd_ptr_q];
            bus.mem_we = 1'b1;
         end
`ifdef FB_READBACK_EN
         GNT_RD:  mem_addr_d = bus.host_rd_addr;
`endif
         default: mem_addr_d = mem_addr_q;
      endcase
   end

   assign bus.mem_addr      = mem_addr_d;
   assign bus.vid_data      = bus.mem_rdata;
   assign bus.vid_valid     = vid_valid_q;
   assign bus.host_wr_ready = !fifo_full;
   assign fifo_level_o      = level_q;
   assign stall_cnt_o       = stall_q;

   // Next-state for FIFO pointers/level, stall counter and read-valid flag.
   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d     = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (!push && pop) begin
         level_d = level_q - LVL_W'(1);
      end
      stall_d     = stall_q;
      if (bus.host_wr_valid && fifo_full && (stall_q != '1)) begin
         stall_d = stall_q + STALL_W'(1);
      end
      vid_valid_d = (grant == GNT_VID);
   end

   // FIFO storage; contents are don't-care until the level says otherwise.
   always_ff @(posedge clkin_i) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= bus.host_wr_addr;
         fifo_data_q[wr_ptr_q] <= bus.host_wr_data;
      end
   end

   // Control state registers.
   always_ff @(posedge clkin_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         stall_q     <= '0;
         mem_addr_q  <= '0;
         vid_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         stall_q     <= stall_d;
         mem_addr_q  <= mem_addr_d;
         vid_valid_q <= vid_valid_d;
      end
   end

`ifdef FB_READBACK_EN
   logic rd_dvalid_q;

   assign bus.host_rd_ready  = (grant == GNT_RD);
   assign bus.host_rd_data   = bus.mem_rdata;
   assign bus.host_rd_dvalid = rd_dvalid_q;

   // Host read data is valid one cycle after its grant, like scan-out.
   always_ff @(posedge clkin_i or posedge rst_i) begin
      if (rst_i) begin
         rd_dvalid_q <= 1'b0;
      end else begin
         rd_dvalid_q <= (grant == GNT_RD);
      end
   end
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: RAM model, scoreboard queues for scan-out reads and
// host writes, directed tests for reset, interleave, backpressure, saturation,
// scan-out line and (with FB_READBACK_EN) host readback.
module tb_fb_mem_arbiter;
   localparam int AW = 15;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fb_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   fb_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();

   logic [2:0]  lvl, lvl4;
   logic [15:0] stall;
   logic [3:0]  stall4;

   fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .STALL_W(16)) dut (
      .clkin_i(clk), .rst_i(rst), .bus(bus), .fifo_level_o(lvl), .stall_cnt_o(stall));

   fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .STALL_W(4)) dut4 (
      .clkin_i(clk), .rst_i(rst), .bus(bus4), .fifo_level_o(lvl4), .stall_cnt_o(stall4));

   assign bus4.vid_req       = bus.vid_req;
   assign bus4.vid_addr      = bus.vid_addr;
   assign bus4.host_wr_valid = bus.host_wr_valid;
   assign bus4.host_wr_addr  = bus.host_wr_addr;
   assign bus4.host_wr_data  = bus.host_wr_data;
   assign bus4.mem_rdata     = '0;
`ifdef FB_READBACK_EN
   assign bus4.host_rd_valid = 1'b0;
   assign bus4.host_rd_addr  = '0;
`endif

   // RAM model: preload a pattern once, then write-first-cycle, read-registered.
   logic [DW-1:0] ram [1<<AW];
   logic          ram_init = 1'b0;
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int a = 0; a < (1<<AW); a++) ram[a] <= DW'(a) ^ 8'h5C;
         ram_init <= 1'b1;
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int n_total = 0;
   int n_bad   = 0;
   int n_vid   = 0;
   int n_wr    = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [DW-1:0]    vid_q[$];
   logic [AW+DW-1:0] wr_q[$];

   // Scoreboard: push on accepted request, pop/compare on DUT output.
   always @(negedge clk) begin
      if (rst) begin
         vid_q.delete();
         wr_q.delete();
      end else begin
         if (bus.vid_valid) begin
            n_vid++;
            if (vid_q.size() == 0) chk("vid_unexpected", 1, 0);
            else chk("vid_data", bus.vid_data, vid_q.pop_front());
         end
         if (bus.mem_we) begin
            n_wr++;
            chk("wr_during_vid", bus.vid_req, 0);
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
               logic [AW+DW-1:0] e;
               e = wr_q.pop_front();
               chk("wr_addr", bus.mem_addr, e[AW+DW-1:DW]);
               chk("wr_data", bus.mem_wdata, e[DW-1:0]);
            end
         end
         if (bus.vid_req) begin
            chk("vid_mem_addr", bus.mem_addr, bus.vid_addr);
            vid_q.push_back(ram[bus.vid_addr]);
         end
         if (bus.host_wr_valid && bus.host_wr_ready)
            wr_q.push_back({bus.host_wr_addr, bus.host_wr_data});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, base_wr, base_vid, gnt_at;
      bus.vid_req = 0; bus.vid_addr = '0;
      bus.host_wr_valid = 0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
`ifdef FB_READBACK_EN
      bus.host_rd_valid = 0; bus.host_rd_addr = '0;
`endif
      // 1: reset held during traffic
      rst = 1'b1;
      tick();
      for (int c = 0; c < 6; c++) begin
         bus.vid_req = 1; bus.vid_addr = AW'($urandom);
         bus.host_wr_valid = 1; bus.host_wr_addr = AW'($urandom); bus.host_wr_data = DW'($urandom);
         @(negedge clk);
         chk("rst_mem_we", bus.mem_we, 0);
         chk("rst_mem_addr", bus.mem_addr, 0);
         tick();
      end
      @(negedge clk);
      chk("rst_vid_valid", bus.vid_valid, 0);
      chk("rst_ready", bus.host_wr_ready, 1);
      chk("rst_level", lvl, 0);
      chk("rst_stall", stall, 0);
`ifdef FB_READBACK_EN
      chk("rst_rd_dvalid", bus.host_rd_dvalid, 0);
`endif
      bus.vid_req = 0; bus.host_wr_valid = 0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rel_ready", bus.host_wr_ready, 1);
      chk("rel_level", lvl, 0);
      tick();

      // 2: interleave vid_req 1/0 with 4 host writes
      base_wr = n_wr; base_vid = n_vid; k = 0;
      for (int c = 0; c < 16; c++) begin
         bus.vid_req = (c % 2 == 0);
         bus.vid_addr = AW'(16'h0100 + c);
         bus.host_wr_valid = (k < 4);
         bus.host_wr_addr = AW'(16'h0010 + k);
         bus.host_wr_data = DW'(8'hA0 + k);
         @(negedge clk);
         if (bus.host_wr_valid && bus.host_wr_ready) k++;
         tick();
      end
      bus.vid_req = 0; bus.host_wr_valid = 0;
      tick(); tick();
      chk("il_writes", n_wr - base_wr, 4);
      chk("il_vid_valids", n_vid - base_vid, 8);
      for (int i = 0; i < 4; i++) chk("il_ram", ram[16 + i], 8'hA0 + i);

      // 3/4: backpressure and stall saturation
      do_reset();
      base_wr = n_wr; k = 0;
      for (int c = 0; c < 20; c++) begin
         bus.vid_req = 1;
         bus.vid_addr = AW'(16'h0200 + c);
         bus.host_wr_valid = 1;
         bus.host_wr_addr = AW'(16'h0030 + k);
         bus.host_wr_data = DW'(8'hB0 + k);
         @(negedge clk);
         if (bus.host_wr_ready) k++;
         tick();
      end
      bus.host_wr_valid = 0;
      @(negedge clk);
      chk("bp_accepted", k, 4);
      chk("bp_level", lvl, 4);
      chk("bp_ready", bus.host_wr_ready, 0);
      chk("bp_stall", stall, 16);
      chk("sat_stall4", stall4, 15);
      chk("bp_no_writes", n_wr - base_wr, 0);
      tick();
      bus.vid_req = 0;
      for (int c = 0; c < 4; c++) tick();
      @(negedge clk);
      chk("drain_level", lvl, 0);
      chk("drain_writes", n_wr - base_wr, 4);
      chk("idle_addr_hold", bus.mem_addr, 16'h0033);
      chk("sat_hold", stall4, 15);
      tick();

      // reset mid-operation discards queued writes
      base_wr = n_wr;
      bus.vid_req = 1;
      for (int c = 0; c < 2; c++) begin
         bus.host_wr_valid = 1;
         bus.host_wr_addr = AW'(16'h0050 + c);
         bus.host_wr_data = DW'(8'hC0 + c);
         tick();
      end
      bus.host_wr_valid = 0;
      do_reset();
      bus.vid_req = 0;
      for (int c = 0; c < 4; c++) tick();
      @(negedge clk);
      chk("midrst_writes", n_wr - base_wr, 0);
      chk("midrst_level", lvl, 0);
      tick();

      // 5: one scan-out line, 2 clocks per pixel, then blanking
      base_vid = n_vid;
      for (int h = 0; h < 320; h++) begin
         bus.vid_req = (h < 256) && (h % 2 == 0);
         bus.vid_addr = AW'(5 * 128 + h / 2);
         tick();
      end
      bus.vid_req = 0;
      tick();
      chk("line_pixels", n_vid - base_vid, 128);

`ifdef FB_READBACK_EN
      // 6: read-after-write waits for the FIFO to drain
      do_reset();
      bus.vid_req = 1;
      bus.host_wr_valid = 1; bus.host_wr_addr = AW'(16'h0042); bus.host_wr_data = 8'h5A;
      tick();
      bus.host_wr_valid = 0;
      bus.host_rd_valid = 1; bus.host_rd_addr = AW'(16'h0042);
      gnt_at = -1;
      for (int i = 0; i < 30 && gnt_at < 0; i++) begin
         bus.vid_req = (i < 3);
         @(negedge clk);
         if (bus.host_rd_ready) begin
            gnt_at = i;
            chk("rd_fifo_empty", lvl, 0);
         end
         tick();
      end
      bus.host_rd_valid = 0;
      chk("rd_grant_cycle", gnt_at, 4);
      @(negedge clk);
      chk("rd_dvalid", bus.host_rd_dvalid, 1);
      chk("rd_data", bus.host_rd_data, 8'h5A);
      tick();
      @(negedge clk);
      chk("rd_dvalid_drop", bus.host_rd_dvalid, 0);
`endif

      chk("vid_q_empty", vid_q.size(), 0);
      chk("wr_q_empty", wr_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
